// File: rtl/communication_unit.sv
// Fetch-unit communication responder: start/stop/end commands throttle fetch via wait_for_next_out.
// Optional forced dependency release is enabled by defining COMM_DEP_TIMEOUT_EN.
module communication_unit #(
  parameter int STOP_HOLD_CYCLES = 4,
  parameter int DEP_TIMEOUT      = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        communication_enable_in,
  input  logic [18:0] communication_signal_in,
  input  logic [15:0] dep_status_in,
  input  logic        signal_ack_in,
  output logic        wait_for_next_out,
  output logic [15:0] signal_out,
  output logic        signal_valid_out,
  output logic        finished_out,
  output logic        dep_timeout_out
);

  typedef enum logic [2:0] {IDLE, WAIT_DEP, SIG_HS, STOP_HOLD, FINISHED} state_t;

  localparam logic [1:0] OP_END   = 2'b00;
  localparam logic [1:0] OP_START = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;
  // One counter serves both the stop hold and the dependency timeout.
  localparam int CNT_MAX = (STOP_HOLD_CYCLES > DEP_TIMEOUT) ? STOP_HOLD_CYCLES : DEP_TIMEOUT;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  state_t            state_reg, state_next;
  logic              enable_d_reg;
  logic [15:0]       mask_reg, mask_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              wait_reg, wait_next;
  logic [15:0]       signal_reg, signal_next;
  logic              valid_reg, valid_next;
  logic              finished_reg, finished_next;
  logic              timeout_reg, timeout_next;

  logic        accept;
  logic        dep_met;
  logic [1:0]  op;
  logic        dep_flag;
  logic [15:0] payload;

  assign op       = communication_signal_in[18:17];
  assign dep_flag = communication_signal_in[16];
  assign payload  = communication_signal_in[15:0];
  assign accept   = (state_reg == IDLE) && communication_enable_in && !enable_d_reg;
  assign dep_met  = (dep_status_in & mask_reg) == mask_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      enable_d_reg <= 1'b0;
      mask_reg     <= '0;
      cnt_reg      <= '0;
      wait_reg     <= 1'b0;
      signal_reg   <= '0;
      valid_reg    <= 1'b0;
      finished_reg <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      enable_d_reg <= communication_enable_in;
      mask_reg     <= mask_next;
      cnt_reg      <= cnt_next;
      wait_reg     <= wait_next;
      signal_reg   <= signal_next;
      valid_reg    <= valid_next;
      finished_reg <= finished_next;
      timeout_reg  <= timeout_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    mask_next     = mask_reg;
    cnt_next      = cnt_reg;
    wait_next     = wait_reg;
    signal_next   = signal_reg;
    valid_next    = valid_reg;
    finished_next = finished_reg;
    timeout_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          case (op)
            OP_START: begin
              if (dep_flag) begin
                mask_next  = payload;
                cnt_next   = '0;
                wait_next  = 1'b1;
                state_next = WAIT_DEP;
              end
            end
            OP_STOP: begin
              wait_next   = 1'b1;
              signal_next = payload;
              valid_next  = 1'b1;
              state_next  = SIG_HS;
            end
            OP_END: begin
              wait_next     = 1'b1;
              finished_next = 1'b1;
              state_next    = FINISHED;
            end
            default: ;
          endcase
        end
      end
      WAIT_DEP: begin
        // A satisfied mask on the timeout cycle takes priority and suppresses the pulse.
        if (dep_met) begin
          wait_next  = 1'b0;
          state_next = IDLE;
        end
`ifdef COMM_DEP_TIMEOUT_EN
        else if (cnt_reg == CNT_W'(DEP_TIMEOUT - 1)) begin
          wait_next    = 1'b0;
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
`endif
      end
      SIG_HS: begin
        if (signal_ack_in) begin
          valid_next = 1'b0;
          cnt_next   = '0;
          if (STOP_HOLD_CYCLES == 0) begin
            wait_next  = 1'b0;
            state_next = IDLE;
          end else begin
            state_next = STOP_HOLD;
          end
        end
      end
      STOP_HOLD: begin
        if (cnt_reg == CNT_W'(STOP_HOLD_CYCLES - 1)) begin
          wait_next  = 1'b0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      FINISHED: ;
      default: state_next = IDLE;
    endcase
  end

  assign wait_for_next_out = wait_reg;
  assign signal_out        = signal_reg;
  assign signal_valid_out  = valid_reg;
  assign finished_out      = finished_reg;
`ifdef COMM_DEP_TIMEOUT_EN
  assign dep_timeout_out   = timeout_reg;
`else
  assign dep_timeout_out   = 1'b0;
`endif

endmodule

// File: tb/tb_communication_unit.sv
// Bench for communication_unit: event-level reference model checked every cycle plus directed scenarios.
module tb_communication_unit;

  localparam int HOLD = 4;
  localparam int DTO  = 8;
`ifdef COMM_DEP_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [18:0] sig = '0;
  logic [15:0] dep = '0;
  logic        ack = 1'b0;
  logic        wait_o;
  logic [15:0] data_o;
  logic        valid_o;
  logic        fin_o;
  logic        to_o;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  communication_unit #(.STOP_HOLD_CYCLES(HOLD), .DEP_TIMEOUT(DTO)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .communication_enable_in (en),
    .communication_signal_in (sig),
    .dep_status_in           (dep),
    .signal_ack_in           (ack),
    .wait_for_next_out       (wait_o),
    .signal_out              (data_o),
    .signal_valid_out        (valid_o),
    .finished_out            (fin_o),
    .dep_timeout_out         (to_o)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks pending obligations rather than states; outputs derive from them.
  bit          m_dep, m_hs, m_end, m_pulse, m_en_prev;
  int          m_hold, m_dcyc;
  logic [15:0] m_mask, m_data;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_dep = 0; m_hs = 0; m_end = 0; m_pulse = 0; m_en_prev = 0;
      m_hold = 0; m_dcyc = 0; m_mask = '0; m_data = '0;
    end else begin
      m_pulse = 0;
      if (m_dep) begin
        m_dcyc++;
        if ((dep & m_mask) == m_mask) m_dep = 0;
        else if (TO_EN && m_dcyc == DTO) begin m_dep = 0; m_pulse = 1; end
      end else if (m_hs) begin
        if (ack) begin m_hs = 0; m_hold = HOLD; end
      end else if (m_hold > 0) begin
        m_hold--;
      end else if (!m_end && en && !m_en_prev) begin
        case (sig[18:17])
          2'b10: if (sig[16]) begin m_dep = 1; m_mask = sig[15:0]; m_dcyc = 0; end
          2'b11: begin m_hs = 1; m_data = sig[15:0]; end
          2'b00: m_end = 1;
          default: ;
        endcase
      end
      m_en_prev = en;
    end
  end

  always @(negedge clock) begin
    chk("wait", 16'(wait_o), 16'(m_dep | m_hs | (m_hold > 0) | m_end));
    chk("valid", 16'(valid_o), 16'(m_hs));
    chk("data", data_o, m_data);
    chk("finished", 16'(fin_o), 16'(m_end));
    chk("dep_timeout", 16'(to_o), 16'(m_pulse));
  end

  int wait_cnt = 0, valid_cnt = 0, to_cnt = 0;
  always @(negedge clock) begin
    if (wait_o)  wait_cnt++;
    if (valid_o) valid_cnt++;
    if (to_o)    to_cnt++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic cmd(input logic [1:0] op, input logic d, input logic [15:0] p);
    sig = {op, d, p};
    en = 1'b1;
    step(1);
    en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int w0, v0, t0;
    step(2);
    #1;
    chk("reset_wait", 16'(wait_o), 16'h0);
    chk("reset_data", data_o, 16'h0);
    reset = 1'b0;
    step(1);

    // 1: reset during stop handshake aborts
    cmd(2'b11, 1'b0, 16'h5555);
    step(1);
    chk("t1_valid_before", 16'(valid_o), 16'h1);
    reset = 1'b1;
    #1;
    chk("t1_valid_reset", 16'(valid_o), 16'h0);
    chk("t1_data_reset", data_o, 16'h0);
    chk("t1_wait_reset", 16'(wait_o), 16'h0);
    step(1);
    reset = 1'b0;
    step(1);
    w0 = wait_cnt;
    cmd(2'b10, 1'b0, 16'h1234);
    step(2);
    chk("t1_indep_wait_cycles", 16'(wait_cnt - w0), 16'h0);

    // 2: dependent start released edge after status set
    w0 = wait_cnt;
    cmd(2'b10, 1'b1, 16'h21E6);
    step(5);
    #1;
    chk("t2_wait_still", 16'(wait_o), 16'h1);
    dep = 16'hFFFF;
    step(1);
    #1;
    chk("t2_wait_drop", 16'(wait_o), 16'h0);
    chk("t2_wait_cycles", 16'(wait_cnt - w0), 16'd6);
    dep = 16'h0;

    // mask 0 gives exactly one wait cycle
    w0 = wait_cnt;
    cmd(2'b10, 1'b1, 16'h0000);
    step(3);
    chk("mask0_wait_cycles", 16'(wait_cnt - w0), 16'd1);

    // 3: stop with ack after 3 cycles
    w0 = wait_cnt; v0 = valid_cnt;
    cmd(2'b11, 1'b0, 16'hA5A5);
    step(2);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    step(6);
    chk("t3_valid_cycles", 16'(valid_cnt - v0), 16'd3);
    chk("t3_wait_cycles", 16'(wait_cnt - w0), 16'd7);
    chk("t3_data_kept", data_o, 16'hA5A5);

    // reserved op ignored
    cmd(2'b01, 1'b1, 16'hFFFF);
    step(2);
    chk("rsv_wait", 16'(wait_o), 16'h0);
    chk("rsv_data", data_o, 16'hA5A5);

    // 4: enable held high is a single command; start during STOP_HOLD ignored
    v0 = valid_cnt; w0 = wait_cnt;
    sig = {2'b11, 1'b0, 16'h1234};
    en = 1'b1;
    ack = 1'b1;
    step(10);
    en = 1'b0;
    ack = 1'b0;
    step(2);
    chk("t4_single_valid", 16'(valid_cnt - v0), 16'd1);
    chk("t4_wait_cycles", 16'(wait_cnt - w0), 16'd5);
    chk("t4_data", data_o, 16'h1234);
    cmd(2'b11, 1'b0, 16'hBEEF);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    cmd(2'b10, 1'b1, 16'hFFFF);
    step(6);
    #1;
    chk("t4_hold_start_ignored", 16'(wait_o), 16'h0);

    // 5: end is terminal until reset
    cmd(2'b00, 1'b0, 16'h0);
    step(1);
    cmd(2'b10, 1'b0, 16'h0);
    step(1);
    cmd(2'b11, 1'b0, 16'hFFFF);
    step(3);
    #1;
    chk("t5_finished", 16'(fin_o), 16'h1);
    chk("t5_wait", 16'(wait_o), 16'h1);
    chk("t5_no_valid", 16'(valid_o), 16'h0);
    chk("t5_data", data_o, 16'hBEEF);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);
    chk("t5_finished_cleared", 16'(fin_o), 16'h0);

    // 6: forced dependency release (only when the option is built in)
    w0 = wait_cnt; t0 = to_cnt;
    cmd(2'b10, 1'b1, 16'h0001);
    step(12);
    if (TO_EN) begin
      chk("t6_wait_cycles", 16'(wait_cnt - w0), 16'd8);
      chk("t6_pulse_count", 16'(to_cnt - t0), 16'd1);
    end else begin
      chk("t6_still_waiting", 16'(wait_o), 16'h1);
      chk("t6_no_pulse", 16'(to_cnt - t0), 16'd0);
    end
    dep = 16'h0001;
    step(2);
    chk("t6_final_release", 16'(wait_o), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
